// File: rtl/half_adder_pkg.sv
// Shared types for the half-adder sweep checker: FSM state encoding and
// the width of the settle-delay counter.
package half_adder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int SETTLE_CNT_W = 4;
  typedef logic [SETTLE_CNT_W-1:0] settle_cnt_t;

endpackage

// File: rtl/adder_model.sv
// Golden reference for the adder under test: WIDTH-bit a+b returned as
// {carry,sum}.
module adder_model #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/half_adder_checker.sv
// Exhaustively sweeps every {a,b} vector into an external adder, waits
// SETTLE cycles per vector, then compares its {c,s} against adder_model.
module half_adder_checker
  import half_adder_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   s,
  input  logic               c,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [2*WIDTH-1:0] first_fail,
  output logic               fail_seen
);

  localparam int VW = 2 * WIDTH;
  // Only meaningful when SETTLE > 0; with SETTLE == 0 DRIVE is never entered.
  localparam settle_cnt_t SETTLE_LAST = settle_cnt_t'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_e      state_q, state_d;
  logic [VW-1:0] idx_q, idx_d;
  settle_cnt_t cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [VW-1:0] ff_q, ff_d;
  logic        fs_q, fs_d;

  logic [WIDTH-1:0] exp_sum;
  logic             exp_carry;
  logic             mismatch;

  adder_model #(.WIDTH(WIDTH)) u_adder_model (
    .a_i    (a),
    .b_i    (b),
    .sum_o  (exp_sum),
    .carry_o(exp_carry)
  );

  assign a        = idx_q[VW-1:WIDTH];
  assign b        = idx_q[WIDTH-1:0];
  assign mismatch = ({c, s} != {exp_carry, exp_sum});

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ff_d    = ff_q;
    fs_d    = fs_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d = '0;
          cnt_d = '0;
          err_d = '0;
          ff_d  = '0;
          fs_d  = 1'b0;
          if (SETTLE == 0) state_d = SAMPLE;
          else             state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!fs_q) begin
            ff_d = idx_q;
            fs_d = 1'b1;
          end
        end
        // The final vector stays on {a,b} while results are held in DONE.
        if (idx_q == '1) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
          cnt_d = '0;
          if (SETTLE == 0) state_d = SAMPLE;
          else             state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fs_q    <= fs_d;
    end
  end

  assign busy       = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done       = (state_q == DONE);
  assign pass       = done && (err_q == '0);
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign fail_seen  = fs_q;

endmodule

// File: tb/tb_half_adder_checker.sv
// Randomized bench for half_adder_checker: two instances (SETTLE=2/ERR_W=8
// and SETTLE=0/ERR_W=2) each test a bench-side adder with selectable faults.
module tb_half_adder_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic       a0, b0, s0, c0, busy0, done0, pass0, fs0;
  logic [7:0] err0;
  logic [1:0] ff0;
  logic       a1, b1, s1, c1, busy1, done1, pass1, fs1;
  logic [1:0] err1;
  logic [1:0] ff1;

  // Fault mode of the adder under test: 0 good, 1 carry stuck-at-0,
  // 2 inverted sum, 3 sum flipped on the vectors selected by mask.
  int         mode = 0;
  logic [3:0] mask = 4'h0;
  int checks = 0;
  int failures = 0;

  function automatic logic [1:0] resp(input int idx, input int md, input logic [3:0] mk);
    int  av, bv, sum;
    logic cc, ss;
    av  = idx / 2;
    bv  = idx % 2;
    sum = av + bv;
    cc  = (sum >= 2);
    ss  = ((sum % 2) == 1);
    if (md == 1) cc = 1'b0;
    if (md == 2) ss = !ss;
    if (md == 3 && mk[idx]) ss = !ss;
    return {cc, ss};
  endfunction

  assign {c0, s0} = resp(int'({a0, b0}), mode, mask);
  assign {c1, s1} = resp(int'({a1, b1}), mode, mask);

  half_adder_checker #(.WIDTH(1), .SETTLE(2), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a0), .b(b0), .s(s0), .c(c0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail(ff0), .fail_seen(fs0)
  );

  half_adder_checker #(.WIDTH(1), .SETTLE(0), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1), .s(s1), .c(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail(ff1), .fail_seen(fs1)
  );

  // Sweep model: t counts cycles since the accepted start; each vector
  // occupies settle+1 cycles and is judged on the last of them.
  typedef struct {
    bit active;
    int t;
    int idx;
    bit done;
    int err;
    int ff;
    bit fs;
  } model_t;

  model_t m0, m1;

  function automatic model_t zero_m();
    model_t z;
    z.active = 0; z.t = 0; z.idx = 0; z.done = 0; z.err = 0; z.ff = 0; z.fs = 0;
    return z;
  endfunction

  function automatic model_t step(input model_t m, input logic st, input int settle,
                                  input int errmax, input int md, input logic [3:0] mk);
    model_t n;
    int     want;
    n = m;
    if (!m.active) begin
      if (st) begin
        n = zero_m();
        n.active = 1;
      end
    end else begin
      if (m.t % (settle + 1) == settle) begin
        want = m.idx / 2 + m.idx % 2;
        if (int'(resp(m.idx, md, mk)) != want) begin
          if (m.err < errmax) n.err = m.err + 1;
          if (!m.fs) begin
            n.fs = 1;
            n.ff = m.idx;
          end
        end
      end
      n.t = m.t + 1;
      if (n.t == 4 * (settle + 1)) begin
        n.active = 0;
        n.done   = 1;
      end else begin
        n.idx = n.t / (settle + 1);
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= zero_m();
      m1 <= zero_m();
    end else begin
      m0 <= step(m0, start, 2, 255, mode, mask);
      m1 <= step(m1, start, 0, 3, mode, mask);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("busy0", busy0, m0.active);
    chk("done0", done0, m0.done);
    chk("pass0", pass0, int'(m0.done && m0.err == 0));
    chk("err0", err0, m0.err);
    chk("ff0", ff0, m0.ff);
    chk("fs0", fs0, m0.fs);
    chk("ab0", {a0, b0}, m0.idx);
    chk("busy1", busy1, m1.active);
    chk("done1", done1, m1.done);
    chk("pass1", pass1, int'(m1.done && m1.err == 0));
    chk("err1", err1, m1.err);
    chk("ff1", ff1, m1.ff);
    chk("fs1", fs1, m1.fs);
    chk("ab1", {a1, b1}, m1.idx);
  end

  // Pulses start, optionally re-pulses it ign_at cycles in, and returns
  // the number of cycles until done0 is seen.
  task automatic run_sweep(output int cyc, input int ign_at);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = (cyc == ign_at);
    end
    start = 1'b0;
    if (!done0) chk("sweep_timeout", 0, 1);
    $display("sweep mode=%0d mask=%h cycles=%0d err0=%0d ff0=%0d err1=%0d pass0=%0d",
             mode, mask, cyc, err0, ff0, err1, pass0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy0, 0);

    mode = 0;
    run_sweep(cyc, -1);
    chk("good_cycles", cyc, 12);
    chk("good_pass", pass0, 1);
    chk("good_err", err0, 0);
    chk("good_fs", fs0, 0);
    chk("done_hold_ab", {a0, b0}, 3);

    mode = 1;
    run_sweep(cyc, 2);
    chk("c0_cycles", cyc, 12);
    chk("c0_err", err0, 1);
    chk("c0_ff", ff0, 3);
    chk("c0_pass", pass0, 0);
    chk("c0_fs", fs0, 1);

    mode = 2;
    run_sweep(cyc, -1);
    chk("inv_err", err0, 4);
    chk("inv_ff", ff0, 0);
    chk("sat_err", err1, 3);
    chk("sat_ff", ff1, 0);

    for (int i = 0; i < 8; i++) begin
      mode = int'($urandom_range(0, 3));
      mask = 4'($urandom);
      run_sweep(cyc, int'($urandom_range(1, 10)));
      chk("rand_cycles", cyc, 12);
    end

    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_done", done0, 0);
    chk("arst_pass", pass0, 0);
    chk("arst_err", err0, 0);
    chk("arst_ff", ff0, 0);
    chk("arst_fs", fs0, 0);
    chk("arst_ab", {a0, b0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_busy", busy0, 0);
    chk("post_done", done0, 0);
    chk("post_ab", {a0, b0}, 0);
    $display("reset mid-sweep: busy0=%0d done0=%0d err0=%0d", busy0, done0, err0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/half_adder_checker.md
HALF_ADDER_CHECKER -- requirements
Module: half_adder_checker

Interface
REQ-001: Parameter WIDTH, default 1, operand width of the adder under test (1 = half adder).
REQ-002: Parameter SETTLE, default 2, idle cycles between driving a vector and sampling the response (range 0..15).
REQ-003: Parameter ERR_W, default 8, width of the error counter.
REQ-004: Port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-005: Port rst_n, input, 1, asynchronous active-low reset.
REQ-006: Port start, input, 1, one-cycle request to begin a sweep.
REQ-007: Port a, output, WIDTH, operand A driven to the adder under test.
REQ-008: Port b, output, WIDTH, operand B driven to the adder under test.
REQ-009: Port s, input, WIDTH, sum returned by the adder under test.
REQ-010: Port c, input, 1, carry returned by the adder under test.
REQ-011: Port busy, output, 1, high while a sweep is in progress.
REQ-012: Port done, output, 1, high from sweep completion until the next start or reset.
REQ-013: Port pass, output, 1, high with done when err_count is zero.
REQ-014: Port err_count, output, ERR_W, count of mismatching vectors, saturating.
REQ-015: Port first_fail, output, 2*WIDTH, {a,b} of the first mismatching vector in the sweep.
REQ-016: Port fail_seen, output, 1, high once any mismatch has been recorded in the current sweep.

Function
REQ-017: The FSM SHALL have exactly four states: IDLE, DRIVE, SAMPLE and DONE.
REQ-018: In IDLE or DONE, start=1 SHALL load vector index 0, clear err_count, first_fail and fail_seen, and enter DRIVE.
REQ-019: start SHALL be ignored in DRIVE and SAMPLE.
REQ-020: The outputs {a,b} SHALL equal the 2*WIDTH-bit vector index, with a in the upper bits, and SHALL be held stable through DRIVE and SAMPLE.
REQ-021: DRIVE SHALL last exactly SETTLE cycles, then enter SAMPLE; with SETTLE=0, the FSM SHALL go directly to SAMPLE.
REQ-022: SAMPLE SHALL last one cycle and compare {c,s} against the expected value a+b, computed at WIDTH+1 bits.
REQ-023: On a mismatch, err_count SHALL increment and saturate at all-ones.
REQ-024: On the first mismatch only, first_fail SHALL capture {a,b} and fail_seen SHALL be set.
REQ-025: After SAMPLE on a non-final index, the index SHALL increment and the FSM SHALL return to DRIVE.
REQ-026: After SAMPLE on the all-ones index, the FSM SHALL enter DONE with no wrap-around.
REQ-027: A full sweep SHALL occupy 2^(2*WIDTH)*(SETTLE+1) cycles from the cycle after start to the first DONE cycle.
REQ-028: busy SHALL be high exactly in DRIVE and SAMPLE.
REQ-029: done SHALL be high exactly in DONE.
REQ-030: pass SHALL equal done AND (err_count==0).
REQ-031: In DONE, {a,b} SHALL hold the final vector, and all results SHALL hold until start.

Reset
REQ-032: rst_n low SHALL asynchronously force the IDLE state and set a, b, busy, done, pass, err_count, first_fail, fail_seen and the index to zero, including mid-sweep.
REQ-033: After rst_n deasserts, the block SHALL remain in IDLE until start.

Structure
REQ-034: The state encoding and the SETTLE counter width (4 bits) SHALL reside in the shared package half_adder_pkg.
REQ-035: The expected-value computation SHALL be one sub-module, adder_model, a combinational WIDTH-bit a+b giving {carry,sum}.
REQ-036: No other sub-modules SHALL be instantiated.

Verification
REQ-037: Correct half adder, WIDTH=1, SETTLE=2; start pulse -> done at cycle 12, pass=1, err_count=0, fail_seen=0.
REQ-038: Carry stuck-at-0 -> err_count=1, first_fail=2'b11, pass=0.
REQ-039: Inverted sum -> err_count=4, first_fail=2'b00.
REQ-040: ERR_W=2 with 4 mismatches -> err_count=3 (saturated).
REQ-041: start while busy is ignored; start in DONE clears err_count and reruns the sweep.
REQ-042: rst_n low at cycle 5 of a sweep -> all outputs 0 immediately, state IDLE, and no activity until start.
